// File: rtl/chaos_sel_gen_if.sv
// Handshake/bus bundle between the chaos select-line generator and its
// consumer (the chaos mux bank plus whoever owns seeding).
interface chaos_sel_gen_if #(
  parameter int W = 16,
  parameter int N = 4
);
  logic         seed_load;
  logic [W-1:0] seed;
  logic         sel_ready;
  logic         sel_valid;
  logic [N-1:0] sel;
  logic [W-1:0] state_o;
  logic         perturbed;

  // Generator side: consumes seed/ready, produces the select stream.
  modport master (
    input  seed_load,
    input  seed,
    input  sel_ready,
    output sel_valid,
    output sel,
    output state_o,
    output perturbed
  );

  // Consumer side: seeds the generator and accepts select vectors.
  modport slave (
    output seed_load,
    output seed,
    output sel_ready,
    input  sel_valid,
    input  sel,
    input  state_o,
    input  perturbed
  );
endinterface

// File: rtl/chaos_sel_gen.sv
// Select-line generator: iterates the r = 4 logistic map on a Q0.W state and
// presents the top N bits of each iterate through a valid/ready handshake.
// Guards stop the orbit from collapsing to zero or sticking on a fixed point
// by mixing in a free-running 16-bit LFSR word.
// W and N must match the parameters of the connected interface instance.
module chaos_sel_gen #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  chaos_sel_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_x;
  logic [15:0]    r_lfsr;
  logic           r_sel_valid;
  logic           r_perturbed;

  logic           w_lfsr_fb;
  logic [W-1:0]   w_p;
  logic [W:0]     w_d;
  logic [2*W:0]   w_prod;
  logic [2*W:0]   w_shift;
  logic           w_sat;
  logic [W-1:0]   w_f;
  logic [W-1:0]   w_mix;
  logic [W-1:0]   w_n;
  logic           w_pert;
  logic [W-1:0]   w_seed_x;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10; all-zero is unreachable
  // from the nonzero reset value.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Perturbation word: the low W bits of the LFSR repeated end to end.
  if (W <= 16) begin : g_p_narrow
    assign w_p = r_lfsr[W-1:0];
  end else begin : g_p_wide
    assign w_p = {r_lfsr[W-17:0], r_lfsr};
  end

  // f = x * (2^W - x) >> (W-2): the map 4x(1-x) in Q0.W. The product needs
  // 2W+1 bits because d reaches 2^W when x is zero.
  assign w_d     = {1'b1, {W{1'b0}}} - {1'b0, r_x};
  assign w_prod  = {{W{1'b0}}, w_d} * {{(W+1){1'b0}}, r_x};
  assign w_shift = w_prod >> (W-2);
  // x = 1/2 lands exactly on 1.0, which Q0.W cannot hold: clamp to all-ones.
  assign w_sat   = |w_shift[2*W:W];
  assign w_f     = w_sat ? {W{1'b1}} : w_shift[W-1:0];
  assign w_mix   = w_f ^ w_p;

  // A zero seed would pin the map at zero forever, so substitute P instead.
  assign w_seed_x = (bus.seed == {W{1'b0}}) ? w_p : bus.seed;

  // Degeneracy guard on the freshly computed iterate.
  always_comb begin
    w_n    = w_f;
    w_pert = 1'b0;
    if ((w_f == {W{1'b0}}) || (w_f == r_x)) begin
      w_pert = 1'b1;
      if (w_mix == {W{1'b0}}) begin
        w_n = w_p;
      end else begin
        w_n = w_mix;
      end
    end else begin
      w_n    = w_f;
      w_pert = 1'b0;
    end
  end

  // Free-running LFSR, advancing every cycle out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Sequencer: seed load, map iteration and output handshake; seed_load
  // overrides everything, including a handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_x         <= {W{1'b0}};
      r_sel_valid <= 1'b0;
      r_perturbed <= 1'b0;
    end else if (bus.seed_load) begin
      r_state     <= ST_CALC;
      r_x         <= w_seed_x;
      r_sel_valid <= 1'b0;
      r_perturbed <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_sel_valid <= 1'b0;
          r_perturbed <= 1'b0;
        end
        ST_CALC: begin
          r_x         <= w_n;
          r_perturbed <= w_pert;
          r_sel_valid <= 1'b1;
          r_state     <= ST_VALID;
        end
        ST_VALID: begin
          r_perturbed <= 1'b0;
          if (r_sel_valid && bus.sel_ready) begin
            r_sel_valid <= 1'b0;
            r_state     <= ST_CALC;
          end else begin
            r_sel_valid <= 1'b1;
            r_state     <= ST_VALID;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_sel_valid <= 1'b0;
          r_perturbed <= 1'b0;
        end
      endcase
    end
  end

  // Outputs come straight from registers; sel is not gated by sel_valid.
  assign bus.sel_valid = r_sel_valid;
  assign bus.sel       = r_x[W-1 -: N];
  assign bus.state_o   = r_x;
  assign bus.perturbed = r_perturbed;

endmodule

// File: tb/tb_chaos_sel_gen.sv
// Self-checking bench for chaos_sel_gen (W=16, N=4). Expected iterates come
// from an arithmetic reference of the map and guard plus a model of the LFSR
// and are queued when a seed load or handshake is driven.
module tb_chaos_sel_gen;
  localparam int W = 16;
  localparam int N = 4;

  typedef struct packed {
    logic [15:0] x;
    logic        pert;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr;
  logic [15:0] m_x;
  exp_t        sb_q[$];

  always #5 clk = ~clk;

  chaos_sel_gen_if #(.W(W), .N(N)) bus ();

  chaos_sel_gen #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference: 4x(1-x) in Q0.16 computed with plain integer arithmetic.
  function automatic exp_t map_ref(input logic [15:0] x, input logic [15:0] p);
    longint unsigned prod;
    longint unsigned f;
    logic [15:0]     fv;
    exp_t            e;
    prod = 64'(x) * (64'd65536 - 64'(x));
    f = prod / 64'd16384;
    if (f > 64'd65535) f = 64'd65535;
    fv = f[15:0];
    e.x = fv;
    e.pert = 1'b0;
    if (fv == 16'd0 || fv == x) begin
      e.pert = 1'b1;
      e.x = fv ^ p;
      if (e.x == 16'd0) e.x = p;
    end
    return e;
  endfunction

  // LFSR model, reset and stepped exactly as the spec describes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called one cycle before the load/handshake edge: the CALC edge that
  // follows uses the LFSR value one step beyond the current model value.
  task automatic push_calc(input logic [15:0] x_in);
    exp_t e;
    e = map_ref(x_in, lfsr_next(m_lfsr));
    sb_q.push_back(e);
    m_x = e.x;
  endtask

  task automatic sb_pop(output exp_t e, output bit empty);
    empty = (sb_q.size() == 0);
    if (!empty) e = sb_q.pop_front();
    else e = '0;
  endtask

  task automatic load_seed(input logic [15:0] s, output logic [15:0] x0);
    x0 = (s == 16'd0) ? m_lfsr : s;
    bus.seed = s;
    bus.seed_load = 1'b1;
    push_calc(x0);
    tick();
    bus.seed_load = 1'b0;
  endtask

  task automatic test_reset;
    bus.seed_load = 1'b0;
    bus.seed = 16'd0;
    bus.sel_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (bus.sel_valid !== 1'b0 || bus.state_o !== 16'd0 || bus.sel !== 4'd0 || bus.perturbed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b state_o=%h sel=%h pert=%b, required 0/0000/0/0",
               bus.sel_valid, bus.state_o, bus.sel, bus.perturbed);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (bus.sel_valid !== 1'b0 || bus.state_o !== 16'd0 || bus.perturbed !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_seed[%0d]: valid=%b state_o=%h pert=%b, required 0/0000/0",
                 i, bus.sel_valid, bus.state_o, bus.perturbed);
      end
    end
  endtask

  task automatic test_fixed_point;
    exp_t e;
    bit emp;
    logic [15:0] x0;
    load_seed(16'h4000, x0);
    n_checks++;
    if (bus.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_calc_valid: valid=%b, required 0", bus.sel_valid);
    end
    tick();
    sb_pop(e, emp);
    n_checks++;
    if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== 16'hC000 || bus.sel !== 4'hC ||
        bus.state_o !== e.x || bus.perturbed !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_first: valid=%b state_o=%h sel=%h pert=%b, required 1/c000/c/0",
               bus.sel_valid, bus.state_o, bus.sel, bus.perturbed);
    end
    bus.sel_ready = 1'b1;
    push_calc(m_x);
    tick();
    bus.sel_ready = 1'b0;
    n_checks++;
    if (bus.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_after_hs_valid: valid=%b, required 0", bus.sel_valid);
    end
    tick();
    sb_pop(e, emp);
    n_checks++;
    if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== e.x || bus.sel !== e.x[15:12] ||
        bus.perturbed !== e.pert) begin
      n_fail++;
      $display("FAIL fp_guarded: valid=%b state_o=%h sel=%h pert=%b, required 1/%h/%h/%b",
               bus.sel_valid, bus.state_o, bus.sel, bus.perturbed, e.x, e.x[15:12], e.pert);
    end
    n_checks++;
    if (bus.perturbed !== 1'b1 || bus.state_o === 16'hC000 || bus.state_o === 16'd0) begin
      n_fail++;
      $display("FAIL fp_guard_fired: pert=%b state_o=%h, required pert=1 and state_o not c000/0000",
               bus.perturbed, bus.state_o);
    end
    tick();
    n_checks++;
    if (bus.perturbed !== 1'b0) begin
      n_fail++;
      $display("FAIL fp_pulse_width: pert=%b, required 0", bus.perturbed);
    end
  endtask

  task automatic test_saturate;
    logic [15:0] tbl_x [3];
    exp_t e;
    bit emp;
    logic [15:0] x0;
    tbl_x[0] = 16'hFFFF; tbl_x[1] = 16'h0003; tbl_x[2] = 16'h000B;
    load_seed(16'h8000, x0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        bus.sel_ready = 1'b1;
        push_calc(m_x);
        tick();
        bus.sel_ready = 1'b0;
        n_checks++;
        if (bus.sel_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL sat_gap[%0d]: valid=%b, required 0", i, bus.sel_valid);
        end
      end
      tick();
      sb_pop(e, emp);
      n_checks++;
      if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== tbl_x[i] || bus.state_o !== e.x ||
          bus.sel !== tbl_x[i][15:12] || bus.perturbed !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_iter[%0d]: valid=%b state_o=%h sel=%h pert=%b, required 1/%h/%h/0",
                 i, bus.sel_valid, bus.state_o, bus.sel, bus.perturbed, tbl_x[i], tbl_x[i][15:12]);
      end
    end
  endtask

  task automatic test_seed_zero;
    exp_t e;
    bit emp;
    logic [15:0] x0;
    load_seed(16'h0000, x0);
    n_checks++;
    if (bus.sel_valid !== 1'b0 || bus.state_o !== x0 || bus.state_o === 16'd0) begin
      n_fail++;
      $display("FAIL zero_seed_load: valid=%b state_o=%h, required 0/%h (nonzero)",
               bus.sel_valid, bus.state_o, x0);
    end
    tick();
    sb_pop(e, emp);
    n_checks++;
    if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== e.x || bus.state_o === 16'd0 ||
        bus.perturbed !== e.pert) begin
      n_fail++;
      $display("FAIL zero_seed_iter: valid=%b state_o=%h pert=%b, required 1/%h/%b",
               bus.sel_valid, bus.state_o, bus.perturbed, e.x, e.pert);
    end
  endtask

  task automatic test_stall;
    exp_t e;
    bit emp;
    logic [15:0] x0;
    load_seed(16'h1234, x0);
    tick();
    sb_pop(e, emp);
    n_checks++;
    if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== e.x || bus.perturbed !== e.pert) begin
      n_fail++;
      $display("FAIL stall_first: valid=%b state_o=%h pert=%b, required 1/%h/%b",
               bus.sel_valid, bus.state_o, bus.perturbed, e.x, e.pert);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus.sel_valid !== 1'b1 || bus.state_o !== e.x || bus.sel !== e.x[15:12] ||
          bus.perturbed !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b state_o=%h sel=%h pert=%b, required 1/%h/%h/0",
                 i, bus.sel_valid, bus.state_o, bus.sel, bus.perturbed, e.x, e.x[15:12]);
      end
    end
    bus.sel_ready = 1'b1;
    push_calc(m_x);
    tick();
    bus.sel_ready = 1'b0;
    n_checks++;
    if (bus.sel_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release_gap: valid=%b, required 0", bus.sel_valid);
    end
    tick();
    sb_pop(e, emp);
    n_checks++;
    if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== e.x || bus.perturbed !== e.pert) begin
      n_fail++;
      $display("FAIL stall_next: valid=%b state_o=%h pert=%b, required 1/%h/%b",
               bus.sel_valid, bus.state_o, bus.perturbed, e.x, e.pert);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit emp;
    logic [15:0] x0;
    load_seed(16'h1357, x0);
    tick();
    sb_pop(e, emp);
    n_checks++;
    if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== e.x || bus.perturbed !== e.pert) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b state_o=%h pert=%b, required 1/%h/%b",
               bus.sel_valid, bus.state_o, bus.perturbed, e.x, e.pert);
    end
    bus.sel_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push_calc(m_x);
      tick();
      n_checks++;
      if (bus.sel_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: valid=%b, required 0", i, bus.sel_valid);
      end
      tick();
      sb_pop(e, emp);
      n_checks++;
      if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== e.x || bus.sel !== e.x[15:12] ||
          bus.perturbed !== e.pert) begin
        n_fail++;
        $display("FAIL b2b_iter[%0d]: valid=%b state_o=%h sel=%h pert=%b, required 1/%h/%h/%b",
                 i, bus.sel_valid, bus.state_o, bus.sel, bus.perturbed, e.x, e.x[15:12], e.pert);
      end
    end
    bus.sel_ready = 1'b0;
  endtask

  task automatic test_seed_vs_handshake_reset;
    exp_t e;
    bit emp;
    logic [15:0] x0;
    // DUT is in VALID: present a handshake and a seed load on the same edge.
    bus.sel_ready = 1'b1;
    load_seed(16'h2000, x0);
    bus.sel_ready = 1'b0;
    n_checks++;
    if (bus.sel_valid !== 1'b0 || bus.state_o !== 16'h2000) begin
      n_fail++;
      $display("FAIL seed_wins: valid=%b state_o=%h, required 0/2000", bus.sel_valid, bus.state_o);
    end
    // Now mid-CALC: reset must clear outputs without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.sel_valid !== 1'b0 || bus.state_o !== 16'd0 || bus.sel !== 4'd0 || bus.perturbed !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b state_o=%h sel=%h pert=%b, required 0/0000/0/0",
               bus.sel_valid, bus.state_o, bus.sel, bus.perturbed);
    end
    sb_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (bus.sel_valid !== 1'b0 || bus.state_o !== 16'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle[%0d]: valid=%b state_o=%h, required 0/0000",
                 i, bus.sel_valid, bus.state_o);
      end
    end
    load_seed(16'h8000, x0);
    tick();
    sb_pop(e, emp);
    n_checks++;
    if (emp || bus.sel_valid !== 1'b1 || bus.state_o !== 16'hFFFF || bus.state_o !== e.x) begin
      n_fail++;
      $display("FAIL reseed_after_reset: valid=%b state_o=%h, required 1/ffff",
               bus.sel_valid, bus.state_o);
    end
  endtask

  initial begin
    test_reset();
    test_fixed_point();
    test_saturate();
    test_seed_zero();
    test_stall();
    test_back_to_back();
    test_seed_vs_handshake_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
